daisy_chain_grant_ctrl: RTL and testbench

Head-of-chain controller for the expandable daisy-chain arbiter. It drives the carry-in of the first arbiter cell to open arbitration. It observes the carry-out of the last cell to detect whether any requester took the grant. It then supervises the winning agent's tenure through a shared busy line, with timeouts, a forced re-arbitration gap and a grant counter.

---
 rtl/daisy_chain_grant_ctrl.sv | 104 ++++++++++
 tb/tb_daisy_chain_grant_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/daisy_chain_grant_ctrl.sv
// daisy_chain_grant_ctrl: head-of-chain controller that opens arbitration, detects the winner and supervises its tenure
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       arbitration enable; 0 parks in IDLE once the current tenure ends
//   chain_cout   carry-out of the last cell; 1 means nobody took the grant
//   busy         wired-OR busy from the granted agent
//   chain_cin    carry-in to the first cell (registered)
//   grant_active high while waiting for busy or holding
//   timeout_err  one-cycle pulse on ack or hold timeout
//   grant_count  completed tenures, saturating at all-ones
module daisy_chain_grant_ctrl #(
    parameter int ACK_TIMEOUT = 8,
    parameter int MAX_HOLD    = 32,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             chain_cout,
    input  logic             busy,
    output logic             chain_cin,
    output logic             grant_active,
    output logic             timeout_err,
    output logic [CNT_W-1:0] grant_count
);
    // The timer also paces the gap, so it must be wide enough for GAP_CYCLES too.
    localparam int TM0  = (ACK_TIMEOUT > MAX_HOLD) ? ACK_TIMEOUT : MAX_HOLD;
    localparam int TMAX = (GAP_CYCLES > TM0) ? GAP_CYCLES : TM0;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {IDLE, OFFER, WAIT_BUSY, HOLD, GAP} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          err_nx, done_nx;

    always_comb begin
        state_nx = state;
        timer_nx = timer + TW'(1);
        err_nx   = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                timer_nx = '0;
                state_nx = enable ? OFFER : IDLE;
            end
            OFFER: begin
                timer_nx = '0;
                state_nx = !enable ? IDLE : (!chain_cout ? WAIT_BUSY : OFFER);
            end
            WAIT_BUSY: begin
                // busy has priority over both withdrawal and the ack timeout
                if (busy) begin
                    state_nx = HOLD;
                    timer_nx = '0;
                end else if (chain_cout || timer == TW'(ACK_TIMEOUT - 1)) begin
                    state_nx = GAP;
                    timer_nx = '0;
                    err_nx   = !chain_cout;
                end
            end
            HOLD: begin
                // chain_cout is ignored here: only busy governs the tenure
                if (!busy || timer == TW'(MAX_HOLD - 1)) begin
                    state_nx = GAP;
                    timer_nx = '0;
                    done_nx  = !busy;
                    err_nx   = busy;
                end
            end
            GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    state_nx = enable ? OFFER : IDLE;
                    timer_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            chain_cin    <= 1'b0;
            grant_active <= 1'b0;
            timeout_err  <= 1'b0;
            grant_count  <= '0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            chain_cin    <= state_nx inside {OFFER, WAIT_BUSY, HOLD};
            grant_active <= state_nx inside {WAIT_BUSY, HOLD};
            timeout_err  <= err_nx;
            if (done_nx && grant_count != '1)
                grant_count <= grant_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_daisy_chain_grant_ctrl.sv
// tb_daisy_chain_grant_ctrl: scoreboard bench for daisy_chain_grant_ctrl against a countdown-based tenure model
module tb_daisy_chain_grant_ctrl;
    localparam int ACK = 8;
    localparam int HLD = 32;
    localparam int GAPC = 2;
    localparam int M_IDLE = 0, M_OFFER = 1, M_WAIT = 2, M_HOLD = 3, M_GAP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic chain_cout = 1'b1;
    logic busy = 1'b0;
    logic chain_cin, grant_active, timeout_err;
    logic [15:0] grant_count;
    logic chain_cin_s, grant_active_s, timeout_err_s;
    logic [1:0] grant_count_s;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    daisy_chain_grant_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .chain_cout(chain_cout), .busy(busy),
        .chain_cin(chain_cin), .grant_active(grant_active), .timeout_err(timeout_err),
        .grant_count(grant_count)
    );

    daisy_chain_grant_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .chain_cout(chain_cout), .busy(busy),
        .chain_cin(chain_cin_s), .grant_active(grant_active_s), .timeout_err(timeout_err_s),
        .grant_count(grant_count_s)
    );

    typedef struct packed {
        logic        cin;
        logic        ga;
        logic        err;
        logic [15:0] cnt;
        logic [1:0]  cnts;
    } exp_t;

    exp_t sb[$];
    int m_mode = M_IDLE;
    int m_left = 0;
    int m_ten = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: each phase carries a budget that counts down; a tenure ends when busy drops.
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        bit err;
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_left = 0;
            m_ten = 0;
            sb.delete();
            e = '0;
            sb.push_back(e);
        end else begin
            err = 0;
            case (m_mode)
                M_IDLE: if (enable) m_mode = M_OFFER;
                M_OFFER: begin
                    if (!enable) m_mode = M_IDLE;
                    else if (!chain_cout) begin m_mode = M_WAIT; m_left = ACK; end
                end
                M_WAIT: begin
                    m_left--;
                    if (busy) begin m_mode = M_HOLD; m_left = HLD; end
                    else if (chain_cout) begin m_mode = M_GAP; m_left = GAPC; end
                    else if (m_left == 0) begin err = 1; m_mode = M_GAP; m_left = GAPC; end
                end
                M_HOLD: begin
                    m_left--;
                    if (!busy) begin m_ten++; m_mode = M_GAP; m_left = GAPC; end
                    else if (m_left == 0) begin err = 1; m_mode = M_GAP; m_left = GAPC; end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_mode = enable ? M_OFFER : M_IDLE;
                end
            endcase
            e.cin  = (m_mode == M_OFFER) || (m_mode == M_WAIT) || (m_mode == M_HOLD);
            e.ga   = (m_mode == M_WAIT) || (m_mode == M_HOLD);
            e.err  = err;
            e.cnt  = (m_ten > 65535) ? 16'hffff : 16'(m_ten);
            e.cnts = (m_ten > 3) ? 2'd3 : 2'(m_ten);
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("chain_cin", {15'd0, chain_cin}, {15'd0, e.cin});
            chk("grant_active", {15'd0, grant_active}, {15'd0, e.ga});
            chk("timeout_err", {15'd0, timeout_err}, {15'd0, e.err});
            chk("grant_count", grant_count, e.cnt);
            chk("s_chain_cin", {15'd0, chain_cin_s}, {15'd0, e.cin});
            chk("s_grant_active", {15'd0, grant_active_s}, {15'd0, e.ga});
            chk("s_timeout_err", {15'd0, timeout_err_s}, {15'd0, e.err});
            chk("s_grant_count", {14'd0, grant_count_s}, {14'd0, e.cnts});
        end
    end

    task automatic drive(input bit e, input bit c, input bit b, input int n);
        enable = e;
        chain_cout = c;
        busy = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_for(input int md, input int lf);
        int n = 0;
        while (!(m_mode == md && m_left == lf) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL wait_for: mode %0d left %0d not reached, want mode %0d left %0d", m_mode, m_left, md, lf);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 10);
        // normal tenure then re-offer
        drive(1, 1, 0, 2);
        drive(1, 0, 0, 2);
        drive(1, 0, 1, 5);
        drive(1, 1, 0, 6);
        // nobody takes the grant
        drive(1, 1, 0, 20);
        // ack timeout
        drive(1, 0, 0, 12);
        drive(1, 1, 0, 4);
        // hold timeout with busy stuck, re-offer enters hold again
        drive(1, 0, 1, 40);
        drive(1, 1, 0, 4);
        // requester withdraws before busy
        drive(1, 0, 0, 3);
        drive(1, 1, 0, 4);
        // enable dropped mid-tenure
        drive(1, 0, 0, 2);
        drive(1, 0, 1, 3);
        drive(0, 0, 1, 3);
        drive(0, 1, 0, 6);
        // enable drop wins over a simultaneous grant detect
        drive(1, 1, 0, 3);
        drive(0, 0, 0, 3);
        // busy arrives on the ack-timeout edge
        drive(1, 0, 0, 1);
        wait_for(M_WAIT, 1);
        drive(1, 0, 1, 3);
        drive(1, 1, 0, 4);
        // busy falls on the hold-limit edge
        drive(1, 0, 1, 1);
        wait_for(M_HOLD, 1);
        drive(1, 1, 0, 4);
        // saturation of the narrow counter
        repeat (5) begin
            drive(1, 0, 0, 2);
            drive(1, 0, 1, 2);
            drive(1, 1, 0, 3);
        end
        chk("sat_count", {14'd0, grant_count_s}, 16'd3);
        // async reset in the middle of a hold
        drive(1, 0, 0, 2);
        drive(1, 0, 1, 3);
        chk("pre_rst_active", {15'd0, grant_active}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cin", {15'd0, chain_cin}, 16'd0);
        chk("rst_active", {15'd0, grant_active}, 16'd0);
        chk("rst_count", grant_count, 16'd0);
        chk("rst_count_s", {14'd0, grant_count_s}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // randomized traffic
        repeat (80) begin
            bit e, c, b;
            int n;
            e = ($urandom_range(0, 9) != 0);
            c = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 2) == 0);
            n = $urandom_range(1, 12);
            if ($urandom_range(0, 15) == 0) n = 40;
            drive(e, c, b, n);
        end
        drive(1, 1, 0, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
